// File: rtl/mac_csr_pkg.sv
// Shared constants for the TSE MAC CSR slave: register offsets, AXI
// response codes and the handshake FSM state encodings.
package mac_csr_pkg;

  localparam logic [4:0] ADDR_VERSION  = 5'h00;
  localparam logic [4:0] ADDR_SCRATCH  = 5'h04;
  localparam logic [4:0] ADDR_CTRL     = 5'h08;
  localparam logic [4:0] ADDR_STATUS   = 5'h0C;
  localparam logic [4:0] ADDR_IRQ_STAT = 5'h10;
  localparam logic [4:0] ADDR_IRQ_MASK = 5'h14;
  localparam logic [4:0] ADDR_EVT_CNT  = 5'h18;
  localparam logic [4:0] ADDR_RSVD     = 5'h1C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

endpackage

// File: rtl/mac_csr_axi4_lite_slave_if.sv
// AXI4-Lite bus bundle between the APB3 bridge (master) and the CSR bank (slave).
// Every channel transfers on the rising edge where valid && ready are both high;
// valid never depends on ready, and payload is held stable while valid waits.
interface mac_csr_axi4_lite_slave_if #(
  parameter int ADDR_WTH = 10
);
  logic [ADDR_WTH-1:0] awaddr;
  logic                awvalid;
  logic                awready;
  logic [31:0]         wdata;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_WTH-1:0] araddr;
  logic                arvalid;
  logic                arready;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/mac_csr_regfile.sv
// CSR storage: address decode, SCRATCH/CTRL/IRQ registers, event counter
// and the combinational read mux.
module mac_csr_regfile
  import mac_csr_pkg::*;
#(
  parameter int          ADDR_WTH = 10,
  parameter logic [31:0] VERSION  = 32'h0001_0000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [ADDR_WTH-1:0] wr_addr,
  input  logic [31:0]         wr_data,
  output logic                wr_err,
  input  logic [ADDR_WTH-1:0] rd_addr,
  output logic [31:0]         rd_data,
  output logic                rd_err,
  input  logic [15:0]         status_i,
  input  logic [7:0]          irq_event_i,
  input  logic                cnt_inc_i,
  output logic [7:0]          ctrl_o,
  output logic                irq_o
);

  logic [31:0] scratch;
  logic [7:0]  ctrl;
  logic [7:0]  irq_stat;
  logic [7:0]  irq_mask;
  logic [31:0] evt_cnt;
  logic        irq_q;
  logic        wr_hit;
  logic [4:0]  wr_sel;
  logic [7:0]  irq_clr;
  logic        cnt_clr;

  // Word-aligned and inside the 32-byte window.
  function automatic logic addr_ok(input logic [ADDR_WTH-1:0] a);
    return ((a >> 5) == '0) && (a[1:0] == 2'b00);
  endfunction

  assign wr_err  = !addr_ok(wr_addr);
  assign wr_hit  = wr_en && !wr_err;
  assign wr_sel  = wr_addr[4:0];
  assign irq_clr = (wr_hit && wr_sel == ADDR_IRQ_STAT) ? wr_data[7:0] : 8'h00;
  assign cnt_clr = wr_hit && wr_sel == ADDR_EVT_CNT;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scratch  <= '0;
      ctrl     <= '0;
      irq_stat <= '0;
      irq_mask <= '0;
      evt_cnt  <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_hit && wr_sel == ADDR_SCRATCH)  scratch  <= wr_data;
      if (wr_hit && wr_sel == ADDR_CTRL)     ctrl     <= wr_data[7:0];
      if (wr_hit && wr_sel == ADDR_IRQ_MASK) irq_mask <= wr_data[7:0];
      // A new event outranks a W1C landing in the same cycle.
      irq_stat <= (irq_stat & ~irq_clr) | irq_event_i;
      if (cnt_clr)        evt_cnt <= '0;
      else if (cnt_inc_i) evt_cnt <= evt_cnt + 32'd1;
      irq_q <= |(irq_stat & irq_mask);
    end
  end

  assign ctrl_o = ctrl;
  assign irq_o  = irq_q;

  always_comb begin
    rd_data = '0;
    rd_err  = !addr_ok(rd_addr);
    if (!rd_err) begin
      case (rd_addr[4:0])
        ADDR_VERSION:  rd_data = VERSION;
        ADDR_SCRATCH:  rd_data = scratch;
        ADDR_CTRL:     rd_data = {24'h0, ctrl};
        ADDR_STATUS:   rd_data = {16'h0, status_i};
        ADDR_IRQ_STAT: rd_data = {24'h0, irq_stat};
        ADDR_IRQ_MASK: rd_data = {24'h0, irq_mask};
        ADDR_EVT_CNT:  rd_data = evt_cnt;
        ADDR_RSVD:     rd_data = '0;
        default:       rd_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/mac_csr_axi4_lite_slave.sv
// AXI4-Lite slave front end for the TSE MAC CSR bank: independent write and
// read handshake FSMs plus the AW/W holding registers around mac_csr_regfile.
module mac_csr_axi4_lite_slave
  import mac_csr_pkg::*;
#(
  parameter int          ADDR_WTH = 10,
  parameter logic [31:0] VERSION  = 32'h0001_0000
) (
  input  logic                              clk,
  input  logic                              rstn,
  mac_csr_axi4_lite_slave_if.slave          s_axi,
  output logic [7:0]                        ctrl_o,
  input  logic [15:0]                       status_i,
  input  logic [7:0]                        irq_event_i,
  input  logic                              cnt_inc_i,
  output logic                              irq_o,
  output wr_state_t                         wr_state,
  output rd_state_t                         rd_state
);

  wr_state_t           wr_state_d;
  rd_state_t           rd_state_d;
  logic                live;
  logic                aw_held;
  logic [ADDR_WTH-1:0] aw_addr_q;
  logic                w_held;
  logic [31:0]         w_data_q;
  logic [1:0]          bresp_q;
  logic [31:0]         rdata_q;
  logic [1:0]          rresp_q;
  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;
  logic                ar_hs;
  logic                commit;
  logic [ADDR_WTH-1:0] wr_addr;
  logic [31:0]         wr_data;
  logic                wr_err;
  logic [31:0]         rd_data;
  logic                rd_err;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;
  assign b_hs  = s_axi.bvalid && s_axi.bready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;

  // A write commits on the edge where the later of AW/W is accepted.
  assign wr_addr = aw_held ? aw_addr_q : s_axi.awaddr;
  assign wr_data = w_held ? w_data_q : s_axi.wdata;

  always_comb begin
    wr_state_d    = wr_state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    commit        = 1'b0;
    case (wr_state)
      W_IDLE: begin
        s_axi.awready = live && !aw_held;
        s_axi.wready  = live && !w_held;
        commit        = (aw_held || aw_hs) && (w_held || w_hs);
        if (commit) wr_state_d = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (b_hs) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d    = rd_state;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        s_axi.arready = live;
        if (ar_hs) rd_state_d = R_DATA;
      end
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // live keeps every ready low while reset is asserted and for the first edge after.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state  <= W_IDLE;
      rd_state  <= R_IDLE;
      live      <= 1'b0;
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      wr_state <= wr_state_d;
      rd_state <= rd_state_d;
      live     <= 1'b1;
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi.awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi.wdata;
      end
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (commit) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign s_axi.bresp = bresp_q;
  assign s_axi.rdata = rdata_q;
  assign s_axi.rresp = rresp_q;

  mac_csr_regfile #(
    .ADDR_WTH (ADDR_WTH),
    .VERSION  (VERSION)
  ) u_regfile (
    .clk         (clk),
    .rstn        (rstn),
    .wr_en       (commit),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .rd_addr     (s_axi.araddr),
    .rd_data     (rd_data),
    .rd_err      (rd_err),
    .status_i    (status_i),
    .irq_event_i (irq_event_i),
    .cnt_inc_i   (cnt_inc_i),
    .ctrl_o      (ctrl_o),
    .irq_o       (irq_o)
  );

endmodule

// File: tb/tb_mac_csr_axi4_lite_slave.sv
// Directed bench for the MAC CSR AXI4-Lite slave with response scoreboards.
module tb_mac_csr_axi4_lite_slave;
  import mac_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] status_i;
  logic [7:0]  irq_event_i;
  logic        cnt_inc_i;
  logic [7:0]  ctrl_o;
  logic        irq_o;
  wr_state_t   wr_state;
  rd_state_t   rd_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];

  always #5 clk = ~clk;

  mac_csr_axi4_lite_slave_if #(.ADDR_WTH(10)) s_axi ();

  mac_csr_axi4_lite_slave #(
    .ADDR_WTH (10),
    .VERSION  (32'h0001_0000)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_axi       (s_axi),
    .ctrl_o      (ctrl_o),
    .status_i    (status_i),
    .irq_event_i (irq_event_i),
    .cnt_inc_i   (cnt_inc_i),
    .irq_o       (irq_o),
    .wr_state    (wr_state),
    .rd_state    (rd_state)
  );

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // order: 0 = AW and W together, 1 = W one cycle after AW, -1 = W one cycle before AW.
  // ev/inc are pulsed in the cycle whose closing edge commits the write.
  task automatic axi_write(input string tag, input logic [9:0] a, input logic [31:0] d,
                           input int order, input logic [1:0] resp,
                           input logic [7:0] ev = 8'h00, input logic inc = 1'b0);
    int n;
    exp_b_q.push_back(resp);
    if (order <= 0) begin
      s_axi.wdata = d; s_axi.wvalid = 1'b1;
      check({tag, "_wready"}, s_axi.wready, 1);
    end
    if (order >= 0) begin
      s_axi.awaddr = a; s_axi.awvalid = 1'b1;
      check({tag, "_awready"}, s_axi.awready, 1);
    end
    if (order == 0) begin irq_event_i = ev; cnt_inc_i = inc; end
    @(negedge clk);
    if (order > 0) begin
      s_axi.awvalid = 1'b0; s_axi.wdata = d; s_axi.wvalid = 1'b1;
      check({tag, "_wready2"}, s_axi.wready, 1);
      irq_event_i = ev; cnt_inc_i = inc;
      @(negedge clk);
    end else if (order < 0) begin
      s_axi.wvalid = 1'b0; s_axi.awaddr = a; s_axi.awvalid = 1'b1;
      check({tag, "_awready2"}, s_axi.awready, 1);
      irq_event_i = ev; cnt_inc_i = inc;
      @(negedge clk);
    end
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    irq_event_i = 8'h00; cnt_inc_i = 1'b0;
    check({tag, "_blat"}, s_axi.bvalid, 1);
    n = 0;
    while (!s_axi.bvalid && n < 10) begin @(negedge clk); n++; end
    s_axi.bready = 1'b1;
    check({tag, "_bresp"}, {s_axi.bvalid, s_axi.bresp}, {1'b1, exp_b_q.pop_front()});
    @(negedge clk);
    s_axi.bready = 1'b0;
    check({tag, "_bdrop"}, s_axi.bvalid, 0);
  endtask

  task automatic axi_read(input string tag, input logic [9:0] a, input logic [31:0] d,
                          input logic [1:0] resp);
    int n;
    exp_r_q.push_back({resp, d});
    s_axi.araddr = a; s_axi.arvalid = 1'b1;
    check({tag, "_arready"}, s_axi.arready, 1);
    @(negedge clk);
    s_axi.arvalid = 1'b0;
    check({tag, "_rlat"}, s_axi.rvalid, 1);
    n = 0;
    while (!s_axi.rvalid && n < 10) begin @(negedge clk); n++; end
    s_axi.rready = 1'b1;
    check({tag, "_rdata"}, {s_axi.rresp, s_axi.rdata}, exp_r_q.pop_front());
    @(negedge clk);
    s_axi.rready = 1'b0;
    check({tag, "_rdrop"}, s_axi.rvalid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0; s_axi.araddr = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
    status_i = 16'h0; irq_event_i = 8'h0; cnt_inc_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs", {s_axi.awready, s_axi.wready, s_axi.arready, s_axi.bvalid,
                       s_axi.rvalid, ctrl_o, irq_o}, 0);
    rstn = 1'b1;
    @(negedge clk);
    axi_read("version", 10'h00, 32'h0001_0000, RESP_OKAY);

    // SCRATCH in both AW/W orders
    axi_write("scr_awfirst", 10'h04, 32'hDEAD_BEEF, 1, RESP_OKAY);
    axi_read("scr_rd1", 10'h04, 32'hDEAD_BEEF, RESP_OKAY);
    axi_write("scr_wfirst", 10'h04, 32'hCAFE_F00D, -1, RESP_OKAY);
    axi_read("scr_rd2", 10'h04, 32'hCAFE_F00D, RESP_OKAY);

    // CTRL keeps 8 bits; STATUS mirrors status_i; reserved word
    axi_write("ctrl_wr", 10'h08, 32'hFFFF_FFA5, 0, RESP_OKAY);
    check("ctrl_o", ctrl_o, 8'hA5);
    axi_read("ctrl_rd", 10'h08, 32'h0000_00A5, RESP_OKAY);
    status_i = 16'hBEEF;
    axi_read("status_rd", 10'h0C, 32'h0000_BEEF, RESP_OKAY);
    axi_write("rsvd_wr", 10'h1C, 32'h5555_5555, 0, RESP_OKAY);
    axi_read("rsvd_rd", 10'h1C, 32'h0, RESP_OKAY);

    // Error responses without side effects
    axi_write("err_wr_oor", 10'h44, 32'h1111_1111, 0, RESP_SLVERR);
    axi_write("err_wr_mis", 10'h09, 32'h2222_2222, 0, RESP_SLVERR);
    check("ctrl_after_err", ctrl_o, 8'hA5);
    axi_read("scr_after_err", 10'h04, 32'hCAFE_F00D, RESP_OKAY);
    axi_read("err_rd_mis", 10'h06, 32'h0, RESP_SLVERR);
    axi_read("err_rd_oor", 10'h40, 32'h0, RESP_SLVERR);

    // Interrupts
    axi_write("mask_wr", 10'h14, 32'h0000_0005, 0, RESP_OKAY);
    axi_read("mask_rd", 10'h14, 32'h0000_0005, RESP_OKAY);
    irq_event_i = 8'h01;
    @(negedge clk);
    irq_event_i = 8'h00;
    check("irq_lag1", irq_o, 0);
    @(negedge clk);
    check("irq_lag2", irq_o, 1);
    axi_write("w1c_race", 10'h10, 32'h0000_0001, 0, RESP_OKAY, 8'h01, 1'b0);
    axi_read("stat_race", 10'h10, 32'h0000_0001, RESP_OKAY);
    check("irq_race", irq_o, 1);
    irq_event_i = 8'h02;
    @(negedge clk);
    irq_event_i = 8'h00;
    axi_read("stat_two", 10'h10, 32'h0000_0003, RESP_OKAY);
    axi_write("w1c_alone", 10'h10, 32'h0000_0003, 0, RESP_OKAY);
    check("irq_fall", irq_o, 0);
    axi_read("stat_clr", 10'h10, 32'h0, RESP_OKAY);

    // Stall with bready/rready low; AR coincides with the SCRATCH write commit
    exp_b_q.push_back(RESP_OKAY);
    exp_r_q.push_back({RESP_OKAY, 32'hCAFE_F00D});
    s_axi.awaddr = 10'h04; s_axi.wdata = 32'h1234_5678;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
    s_axi.araddr = 10'h04; s_axi.arvalid = 1'b1;
    @(negedge clk);
    s_axi.wvalid = 1'b0; s_axi.arvalid = 1'b0;
    s_axi.awaddr = 10'h08; s_axi.wdata = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      check("stall_b", {s_axi.bvalid, s_axi.awready, s_axi.wready}, 3'b100);
      check("stall_r", {s_axi.rvalid, s_axi.arready, s_axi.rdata}, {2'b10, 32'hCAFE_F00D});
      @(negedge clk);
    end
    s_axi.awvalid = 1'b0;
    s_axi.bready = 1'b1; s_axi.rready = 1'b1;
    check("stall_bresp", {s_axi.bvalid, s_axi.bresp}, {1'b1, exp_b_q.pop_front()});
    check("stall_rdata", {s_axi.rresp, s_axi.rdata}, exp_r_q.pop_front());
    @(negedge clk);
    s_axi.bready = 1'b0; s_axi.rready = 1'b0;
    check("stall_aw_not_taken", {s_axi.awready, s_axi.wready, s_axi.bvalid}, 3'b110);
    check("stall_ctrl", ctrl_o, 8'hA5);
    axi_read("scr_after_stall", 10'h04, 32'h1234_5678, RESP_OKAY);

    // Event counter
    axi_read("cnt_zero", 10'h18, 32'h0, RESP_OKAY);
    cnt_inc_i = 1'b1;
    repeat (3) @(negedge clk);
    cnt_inc_i = 1'b0;
    axi_read("cnt_three", 10'h18, 32'd3, RESP_OKAY);
    axi_write("cnt_clr_race", 10'h18, 32'hFFFF_FFFF, 0, RESP_OKAY, 8'h00, 1'b1);
    axi_read("cnt_cleared", 10'h18, 32'h0, RESP_OKAY);
    force dut.u_regfile.evt_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.u_regfile.evt_cnt;
    cnt_inc_i = 1'b1;
    @(negedge clk);
    cnt_inc_i = 1'b0;
    axi_read("cnt_max", 10'h18, 32'hFFFF_FFFF, RESP_OKAY);
    cnt_inc_i = 1'b1;
    @(negedge clk);
    cnt_inc_i = 1'b0;
    axi_read("cnt_wrap", 10'h18, 32'h0, RESP_OKAY);

    // Reset in the middle of a write response
    s_axi.awaddr = 10'h04; s_axi.wdata = 32'h0BAD_0BAD;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
    @(negedge clk);
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    check("abort_bvalid_pre", s_axi.bvalid, 1);
    rstn = 1'b0;
    #1;
    check("abort_rst_outs", {s_axi.bvalid, s_axi.awready, s_axi.arready, ctrl_o}, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_b", s_axi.bvalid, 0);
    axi_read("abort_scr", 10'h04, 32'h0, RESP_OKAY);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mac_csr_axi4_lite_slave.md
# mac_csr_axi4_lite_slave

AXI4-Lite slave register bank for the TSE MAC control/status space, directly downstream of the APB3→AXI4-Lite bridge. It accepts AW/W/B and AR/R transactions and decodes word addresses into eight 32-bit registers: version, scratch, control, status, interrupt status/mask and an event counter. Unmapped or misaligned accesses complete with SLVERR and have no side effects.

## Interface
- ADDR_WTH, 10, byte-address width.
- VERSION, 32'h0001_0000, value returned by the VERSION register.
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  ADDR_WTH  write byte address.
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake.
- s_axi_wdata  in  32  write data (no strobes; full-word writes only).
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake.
- s_axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake.
- s_axi_araddr  in  ADDR_WTH  read byte address.
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response, same encoding as bresp.
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake.
- ctrl_o  out  8  CTRL register contents.
- status_i  in  16  live MAC status, readable through STATUS.
- irq_event_i  in  8  one-cycle interrupt event pulses.
- cnt_inc_i  in  1  event-counter increment strobe.
- irq_o  out  1  registered `|(IRQ_STAT & IRQ_MASK)`.

## Operation
- Register map (byte offsets):
  - 0x00 VERSION: RO.
  - 0x04 SCRATCH: RW, 32 bits.
  - 0x08 CTRL: RW, bits [7:0]; other bits read 0.
  - 0x0C STATUS: RO, `{16'h0, status_i}`.
  - 0x10 IRQ_STAT: W1C, bits [7:0].
  - 0x14 IRQ_MASK: RW, bits [7:0].
  - 0x18 EVT_CNT: RO 32-bit counter; any write clears it.
  - 0x1C: reserved. Reads 0 with OKAY; writes are ignored with OKAY.
- Error responses:
  - An address ≥ 0x20 → SLVERR.
  - `addr[1:0] != 0` → SLVERR.
  - An SLVERR read returns rdata = 0.
- Write FSM has two states:
  - W_IDLE: awready = !aw_held, wready = !w_held. AW and W are latched independently and may arrive in either order or in the same cycle. When both are held, the write commits on the next edge, bvalid is set, and the FSM moves to W_RESP.
  - W_RESP: awready = wready = 0. On bvalid && bready, clear both held flags and return to W_IDLE.
- Read FSM has two states:
  - R_IDLE: arready = 1. On the AR handshake, rdata/rresp are captured at that edge and the FSM moves to R_DATA.
  - R_DATA: arready = 0, rvalid = 1, rdata held stable. On rready, return to R_IDLE.
- Read and write paths are independent and may be active simultaneously.
- Read/write collision on the same register: when an AR handshake edge coincides with a write commit edge, the read returns the pre-write value.
- IRQ_STAT bit i: set by irq_event_i[i]. If a set and a W1C clear land in the same cycle, the set wins.
- EVT_CNT increments by 1 per cnt_inc_i and wraps 0xFFFF_FFFF → 0. If a clear-write and an increment land in the same cycle, the result is 0.
- Reset values: every output is 0, and all registers except VERSION reset to 0. Reset asserted mid-transaction aborts it; no response is issued after reset.

## Timing
- Write latency: AW and W accepted in the same cycle N → bvalid at N+1. If W arrives later, bvalid appears one cycle after the later of the two handshakes.
- Write side effects (ctrl_o, IRQ_MASK) are visible at N+1, coincident with bvalid.
- Read latency: AR handshake at N → rvalid at N+1. Back-to-back reads with rready tied high sustain one read every 2 cycles.
- status_i is sampled at the AR handshake edge.
- irq_o lags IRQ_STAT/IRQ_MASK by one cycle (registered).

## Structure
- Shared package `mac_csr_pkg` holds:
  - register offset constants;
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - write-FSM and read-FSM state encodings.
- Sub-module `mac_csr_regfile`: register storage, the address decode/valid function, IRQ set/clear logic, the counter and the read mux.
- The top level holds only the AXI handshake FSMs and the AW/W holding registers.

## Test plan
- Reset → VERSION read returns 32'h0001_0000 with OKAY. ctrl_o = 0, irq_o = 0, all valids and readys low during reset.
- SCRATCH: AW with W one cycle later, data 32'hDEAD_BEEF → bresp OKAY one cycle after W. Read back returns DEAD_BEEF. Repeat with W before AW; same result.
- Write to 0x40 → bresp SLVERR, no register changes. Read 0x06 → rresp SLVERR, rdata 0.
- IRQ: mask = 8'h05, pulse irq_event_i = 8'h01 → irq_o = 1 two cycles after the pulse. W1C 8'h01 in the same cycle as another event on bit 0 → bit stays set. W1C alone → irq_o falls.
- bready/rready held low for 5 cycles → bvalid and rvalid/rdata stay stable, awready/wready/arready stay 0. A new AW offered meanwhile is not accepted.
- EVT_CNT: 3 increments → reads 3. Write to EVT_CNT coinciding with an increment → reads 0. Preload via 2^32 increments (or force) → wraps to 0.
